// File: rtl/deratematching_inputbuffer_reader_if.sv
// ---------------------------------------------------------------------------
// deratematching_inputbuffer_reader_if
// Valid/ready output stream of the de-rate-matching input buffer reader.
//   o_data  : one user lane word (FIFO head)
//   o_valid : word available
//   o_last  : final word of the transfer
//   i_ready : downstream accepts the word this cycle
// master = reader side, slave = downstream consumer.
// ---------------------------------------------------------------------------
interface deratematching_inputbuffer_reader_if #(
    parameter int DATA_W = 48
);
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_last;
    logic              i_ready;

    modport master (output o_data, output o_valid, output o_last, input i_ready);
    modport slave  (input o_data, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/deratematching_inputbuffer_reader.sv
// ---------------------------------------------------------------------------
// deratematching_inputbuffer_reader
// Read-side controller of the 16-user de-rate-matching input buffer.
// A start command latches user, first address and length; the block then
// walks a wrapping address range on o_rd_addr, picks the selected user's
// lane from the common read bus one cycle later and streams it out through
// a 4-entry first-word-fall-through FIFO whose free space is tracked as
// credit, so RAM latency and downstream stalls never overflow it.
// Ports:
//   i_core_clk / i_rx_rstn      : clock, async active-low reset
//   i_start, i_user_sel,
//   i_start_addr, i_length      : transfer command (taken only in IDLE)
//   o_rd_addr / i_rd_data       : common buffer read port (1-cycle latency)
//   strm                        : output stream (data/valid/last/ready)
//   o_busy / o_done             : transfer in progress / completion pulse
// ---------------------------------------------------------------------------
module deratematching_inputbuffer_reader #(
    parameter int DATA_W     = 48,
    parameter int ADDR_W     = 11,
    parameter int NUM_USERS  = 16,
    parameter int SEL_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_core_clk,
    input  logic                        i_rx_rstn,
    input  logic                        i_start,
    input  logic [SEL_W-1:0]            i_user_sel,
    input  logic [ADDR_W-1:0]           i_start_addr,
    input  logic [ADDR_W:0]             i_length,
    output logic [ADDR_W-1:0]           o_rd_addr,
    input  logic [DATA_W*NUM_USERS-1:0] i_rd_data,
    deratematching_inputbuffer_reader_if.master strm,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              iss_q, iss_d;            // address on the bus this cycle
    logic              iss_last_q, iss_last_d;
    logic              cap_q, cap_d;            // read data on the bus this cycle
    logic              cap_last_q, cap_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;

    logic              issue_s;
    logic              issue_last_s;
    logic              can_issue_s;
    logic              push_s;
    logic              pop_s;
    logic              head_last_s;
    logic [CNT_W:0]    credit_used_s;
    logic [DATA_W-1:0] lane_s;

    assign lane_s        = i_rd_data[sel_q*DATA_W +: DATA_W];
    assign head_last_s   = fifo_last_q[rd_ptr_q];
    assign push_s        = cap_q;
    assign pop_s         = (fifo_count_q != '0) && strm.i_ready;
    // Words already stored plus words still travelling through the RAM
    // pipeline must never exceed the FIFO size.
    assign credit_used_s = {1'b0, fifo_count_q} + (CNT_W+1)'(iss_q) + (CNT_W+1)'(cap_q);
    assign can_issue_s   = credit_used_s < (CNT_W+1)'(FIFO_DEPTH);

    // Transfer FSM: command capture, address generation and completion.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rd_addr_d    = rd_addr_q;
        rem_d        = rem_q;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !done_q) begin
                    sel_d = i_user_sel;
                    if (i_length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First address goes out on the start edge itself.
                        issue_s   = 1'b1;
                        rd_addr_d = i_start_addr;
                        rem_d     = i_length - (ADDR_W+1)'(1);
                        if (i_length == (ADDR_W+1)'(1)) begin
                            issue_last_s = 1'b1;
                            state_d      = ST_DRAIN;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // rem_q counts words still to issue, including this one.
                if (can_issue_s) begin
                    issue_s   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rem_d     = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        issue_last_s = 1'b1;
                        state_d      = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d     = (state_d != ST_IDLE);
        iss_d      = issue_s;
        iss_last_d = issue_last_s;
        cap_d      = iss_q;
        cap_last_d = iss_last_q;
    end

    // Output FIFO next-state: push captured lane, pop on handshake.
    always_comb begin
        fifo_data_d  = fifo_data_q;
        fifo_last_d  = fifo_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push_s) begin
            fifo_data_d[wr_ptr_q] = lane_s;
            fifo_last_d[wr_ptr_q] = cap_last_q;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State registers; reset clears everything so all outputs read 0.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            rd_addr_q    <= '0;
            rem_q        <= '0;
            iss_q        <= 1'b0;
            iss_last_q   <= 1'b0;
            cap_q        <= 1'b0;
            cap_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fifo_data_q  <= '{default: '0};
            fifo_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rd_addr_q    <= rd_addr_d;
            rem_q        <= rem_d;
            iss_q        <= iss_d;
            iss_last_q   <= iss_last_d;
            cap_q        <= cap_d;
            cap_last_q   <= cap_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fifo_data_q  <= fifo_data_d;
            fifo_last_q  <= fifo_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    assign o_rd_addr    = rd_addr_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign strm.o_valid = (fifo_count_q != '0);
    assign strm.o_data  = fifo_data_q[rd_ptr_q];
    // Gate the tag so a stale head entry never shows last while empty.
    assign strm.o_last  = (fifo_count_q != '0) && head_last_s;

endmodule

// File: tb/tb_deratematching_inputbuffer_reader.sv
module tb_deratematching_inputbuffer_reader;

    localparam int DATA_W    = 48;
    localparam int ADDR_W    = 11;
    localparam int NUM_USERS = 16;
    localparam int SEL_W     = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        i_start = 1'b0;
    logic [SEL_W-1:0]            user_sel = '0;
    logic [ADDR_W-1:0]           start_addr = '0;
    logic [ADDR_W:0]             length = '0;
    logic [ADDR_W-1:0]           rd_addr;
    logic [DATA_W*NUM_USERS-1:0] rd_data = '0;
    logic                        busy;
    logic                        done;
    logic                        ready = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic        hold_chk = 1'b0;
    logic [63:0] hold_val = '0;

    deratematching_inputbuffer_reader_if #(.DATA_W(DATA_W)) strm ();
    assign strm.i_ready = ready;

    deratematching_inputbuffer_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_USERS(NUM_USERS), .SEL_W(SEL_W), .FIFO_DEPTH(4)
    ) dut (
        .i_core_clk  (clk),
        .i_rx_rstn   (rst_n),
        .i_start     (i_start),
        .i_user_sel  (user_sel),
        .i_start_addr(start_addr),
        .i_length    (length),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .strm        (strm),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] lane_word(input int lane, input int addr);
        logic [15:0] hi;
        logic [10:0] a;
        logic [15:0] lo;
        hi = 16'(lane * 4369) ^ 16'hC3A5;
        a  = 11'(addr);
        lo = 16'(addr * 7 + lane * 331);
        return {hi, 5'd0, a, lo};
    endfunction

    function automatic logic [DATA_W*NUM_USERS-1:0] ram_row(input logic [ADDR_W-1:0] a);
        logic [DATA_W*NUM_USERS-1:0] row;
        row = '0;
        for (int k = 0; k < NUM_USERS; k++) row[k*DATA_W +: DATA_W] = lane_word(k, int'(a));
        return row;
    endfunction

    // Buffer model: address seen in cycle n returns its row in cycle n+1.
    always @(posedge clk) rd_data <= ram_row(rd_addr);

    // Scoreboard and stream-rule monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (hold_chk) check("stall_hold", {14'd0, strm.o_valid, strm.o_last, strm.o_data}, hold_val);
        hold_chk <= rst_n && strm.o_valid && !ready;
        hold_val <= {14'd0, strm.o_valid, strm.o_last, strm.o_data};
        if (rst_n) check("fifo_le_depth", 64'(dut.fifo_count_q <= 3'd4), 64'd1);
        if (strm.o_valid && ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                check("data", 64'(strm.o_data), 64'(sb_q[0].d));
                check("last", 64'(strm.o_last), 64'(sb_q[0].l));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic push_expected(input int sel, input int addr, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.d = lane_word(sel, (addr + i) % 2048);
            e.l = (i == len - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic start_cmd(input int sel, input int addr, input int len);
        @(posedge clk); #1;
        i_start    = 1'b1;
        user_sel   = SEL_W'(sel);
        start_addr = ADDR_W'(addr);
        length     = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // mode 0: always ready, cycle-exact checks
    // mode 1: ready low in cycles 4..10
    // mode 2: always ready, ignored second start at cycle 500
    task automatic run(input int sel, input int addr, input int len, input int mode);
        int c;
        int done_cnt;
        int last_c;
        bit timed;
        timed    = (mode != 1);
        last_c   = timed ? len + 4 : len + 60;
        done_cnt = 0;
        push_expected(sel, addr, len);
        ready = 1'b1;
        start_cmd(sel, addr, len);
        c = 1;
        while (c <= last_c) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (timed) begin
                check("busy",  64'(busy),        64'(len > 0 && c <= len + 2));
                check("done",  64'(done),        64'((len == 0) ? (c == 1) : (c == len + 3)));
                check("valid", 64'(strm.o_valid), 64'(len > 0 && c >= 3 && c <= len + 2));
                check("last_cycle", 64'(strm.o_last), 64'(len > 0 && c == len + 2));
                if (c <= len) check("rd_addr", 64'(rd_addr), 64'((addr + c - 1) % 2048));
            end
            @(posedge clk); #1;
            c++;
            if (mode == 2 && c == 500) begin
                i_start    = 1'b1;
                user_sel   = SEL_W'(5);
                start_addr = ADDR_W'(7);
                length     = (ADDR_W+1)'(3);
            end else begin
                i_start = 1'b0;
            end
            ready = !(mode == 1 && c >= 4 && c <= 10);
        end
        check("done_count", 64'(done_cnt), 64'd1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_data"},    64'(strm.o_data), 64'd0);
        check({tag, "_valid"},   64'(strm.o_valid), 64'd0);
        check({tag, "_last"},    64'(strm.o_last), 64'd0);
        check({tag, "_busy"},    64'(busy), 64'd0);
        check({tag, "_done"},    64'(done), 64'd0);
    endtask

    initial begin
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run(3, 10, 4, 0);
        run(15, 2046, 4, 0);
        run(2, 500, 8, 1);
        run(7, 33, 0, 0);

        // Abort a 20-word transfer with reset in cycle 5.
        push_expected(1, 50, 20);
        start_cmd(1, 50, 20);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        sb_q.delete();
        repeat (2) @(negedge clk);
        check_outputs_zero("abort_hold");
        rst_n = 1'b1;
        run(0, 0, 2, 0);

        run(9, 100, 2048, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
